// File: rtl/ctrl_io_dr_pkg.sv
// Shared types and dual-rail encoding helpers for the ctrl_IO tile sequencer.
package ctrl_io_dr_pkg;

  typedef enum logic {
    PRECH = 1'b0,
    EVAL  = 1'b1
  } dr_phase_e;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ZERO = 2'b01;

  typedef struct packed {
    logic valid;
    logic data;
  } dr_dec_t;

  // rails are {t, f}; 00 and 11 carry no legal value
  function automatic dr_dec_t dr_decode(input logic [1:0] rails);
    dr_dec_t r;
    r.valid = 1'b0;
    r.data  = 1'b0;
    case (rails)
      DR_ONE: begin
        r.valid = 1'b1;
        r.data  = 1'b1;
      end
      DR_ZERO: begin
        r.valid = 1'b1;
        r.data  = 1'b0;
      end
      default: begin
        r.valid = 1'b0;
        r.data  = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_io_dr_fifo.sv
// Single-clock transmit FIFO with registered full/empty flags and no fall-through.
module ctrl_io_dr_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // pointers carry one extra wrap bit to tell full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ctrl_io_dr_sequencer.sv
// Precharge/evaluate dual-rail sequencer for the ctrl_IO tile top-side pins:
// encodes FIFO bits onto O rails, decodes returned I rails, tracks faults.
module ctrl_io_dr_sequencer
  import ctrl_io_dr_pkg::*;
#(
  parameter int EVAL_CYCLES = 1,
  parameter int FIFO_DEPTH  = 2,
  parameter int CNT_W       = 8
) (
  input  logic             UserCLK,
  input  logic             rst,
  input  logic             run,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             O_top_0_t,
  output logic             O_top_0_f,
  output logic             prech2,
  output logic             DR_fault,
  input  logic             I_top_0_t,
  input  logic             I_top_0_f,
  input  logic             T_top,
  input  logic             F_ctrl,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_oe,
  output logic             out_err,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam logic [3:0]       EVAL_LOAD = 4'(EVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  dr_phase_e        state_q;
  logic [3:0]       eval_cnt_q;
  logic             prech2_q;
  logic [1:0]       o_rails_q;
  logic             settle_q;
  logic             out_valid_q, out_data_q, out_oe_q, out_err_q;
  logic             dr_fault_q;
  logic [CNT_W-1:0] fault_cnt_q;

  logic       fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;
  logic       start_beat, end_beat;
  logic [1:0] i_rails;
  dr_dec_t    dec;
  logic       prech_bad, sample_bad, fault_any;

  ctrl_io_dr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (UserCLK),
    .rst_n(rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  // being in PRECH at an edge means a whole precharge cycle has already elapsed
  assign start_beat = (state_q == PRECH) && run && !fifo_empty;
  assign end_beat   = (state_q == EVAL) && (eval_cnt_q == 4'd0);
  assign fifo_pop   = start_beat;

  assign i_rails    = {I_top_0_t, I_top_0_f};
  assign dec        = dr_decode(i_rails);
  assign prech_bad  = (state_q == PRECH) && !settle_q && (i_rails != DR_NULL);
  assign sample_bad = end_beat && !dec.valid;
  assign fault_any  = prech_bad || sample_bad || F_ctrl;

  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      state_q     <= PRECH;
      eval_cnt_q  <= 4'd0;
      prech2_q    <= 1'b1;
      o_rails_q   <= DR_NULL;
      settle_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_oe_q    <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      settle_q    <= 1'b0;
      case (state_q)
        PRECH: begin
          if (start_beat) begin
            state_q    <= EVAL;
            eval_cnt_q <= EVAL_LOAD;
            prech2_q   <= 1'b0;
            o_rails_q  <= fifo_dout ? DR_ONE : DR_ZERO;
          end
        end
        EVAL: begin
          if (eval_cnt_q == 4'd0) begin
            state_q     <= PRECH;
            prech2_q    <= 1'b1;
            o_rails_q   <= DR_NULL;
            settle_q    <= 1'b1;
            out_oe_q    <= ~T_top;
            out_valid_q <= dec.valid;
            out_err_q   <= !dec.valid;
            if (dec.valid) begin
              out_data_q <= dec.data;
            end
          end else begin
            eval_cnt_q <= eval_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= PRECH;
          prech2_q  <= 1'b1;
          o_rails_q <= DR_NULL;
        end
      endcase
    end
  end

  // a new fault in the same cycle as a clear restarts the count at one
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      dr_fault_q  <= 1'b0;
      fault_cnt_q <= '0;
    end else if (fault_any) begin
      dr_fault_q <= 1'b1;
      if (fault_clr) begin
        fault_cnt_q <= CNT_ONE;
      end else if (fault_cnt_q != CNT_MAX) begin
        fault_cnt_q <= fault_cnt_q + CNT_ONE;
      end
    end else if (fault_clr) begin
      dr_fault_q  <= 1'b0;
      fault_cnt_q <= '0;
    end
  end

  assign prech2    = prech2_q;
  assign O_top_0_t = o_rails_q[1];
  assign O_top_0_f = o_rails_q[0];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_oe    = out_oe_q;
  assign out_err   = out_err_q;
  assign DR_fault  = dr_fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_ctrl_io_dr_sequencer.sv
// Scoreboard bench for ctrl_io_dr_sequencer with an O->I loopback that can be overridden.
module tb_ctrl_io_dr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // primary instance, EVAL_CYCLES = 1
  logic       run = 1'b0, in_valid = 1'b0, in_data = 1'b0, in_ready;
  logic       o_t, o_f, prech2, dr_fault, i_t, i_f;
  logic       t_top = 1'b0, f_ctrl = 1'b0, fault_clr = 1'b0;
  logic       o_valid, o_data, o_oe, o_err;
  logic [7:0] fault_cnt;
  logic       force_en = 1'b0;
  logic [1:0] force_rails = 2'b00;

  assign i_t = force_en ? force_rails[1] : o_t;
  assign i_f = force_en ? force_rails[0] : o_f;

  ctrl_io_dr_sequencer #(.EVAL_CYCLES(1), .FIFO_DEPTH(2), .CNT_W(8)) dut (
    .UserCLK(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .O_top_0_t(o_t), .O_top_0_f(o_f), .prech2(prech2),
    .DR_fault(dr_fault), .I_top_0_t(i_t), .I_top_0_f(i_f), .T_top(t_top),
    .F_ctrl(f_ctrl), .out_valid(o_valid), .out_data(o_data), .out_oe(o_oe),
    .out_err(o_err), .fault_clr(fault_clr), .fault_cnt(fault_cnt)
  );

  // second instance, EVAL_CYCLES = 3, plain loopback
  logic       r3_run = 1'b0, r3_in_valid = 1'b0, r3_in_data = 1'b0, r3_in_ready;
  logic       r3_o_t, r3_o_f, r3_prech2, r3_dr_fault;
  logic       r3_valid, r3_data, r3_oe, r3_err;
  logic [7:0] r3_fault_cnt;

  ctrl_io_dr_sequencer #(.EVAL_CYCLES(3), .FIFO_DEPTH(2), .CNT_W(8)) dut3 (
    .UserCLK(clk), .rst(rst), .run(r3_run), .in_valid(r3_in_valid), .in_data(r3_in_data),
    .in_ready(r3_in_ready), .O_top_0_t(r3_o_t), .O_top_0_f(r3_o_f), .prech2(r3_prech2),
    .DR_fault(r3_dr_fault), .I_top_0_t(r3_o_t), .I_top_0_f(r3_o_f), .T_top(1'b0),
    .F_ctrl(1'b0), .out_valid(r3_valid), .out_data(r3_data), .out_oe(r3_oe),
    .out_err(r3_err), .fault_clr(1'b0), .fault_cnt(r3_fault_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic err;
    logic data;
    logic oe;
  } beat_t;

  beat_t sb_q[$];
  beat_t sb_exp;

  always @(negedge clk) begin
    if (rst && (o_valid || o_err)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", {30'd0, o_valid, o_err}, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_eq("sb_err", o_err, sb_exp.err);
        check_eq("sb_valid", o_valid, !sb_exp.err);
        if (!sb_exp.err) check_eq("sb_data", o_data, sb_exp.data);
        check_eq("sb_oe", o_oe, sb_exp.oe);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] exp_rails [7] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic       exp_prech [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       exp_vld   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       push_bits [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int low_cnt, vld_cnt, waited;
    logic got_data;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_prech2", prech2, 1'b1);
    check_eq("rst_rails", {o_t, o_f}, 2'b00);
    check_eq("rst_fault", dr_fault, 1'b0);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_data_oe_err", {o_data, o_oe, o_err}, 3'b000);
    check_eq("rst_cnt", fault_cnt, 8'd0);
    check_eq("rst_ready", in_ready, 1'b1);
    rst = 1'b1;
    run = 1'b1;
    r3_run = 1'b1;
    @(negedge clk);

    // back-to-back 1,0,1 through the loopback
    for (int k = 0; k < 3; k++) sb_q.push_back('{err: 1'b0, data: push_bits[k], oe: 1'b1});
    in_valid = 1'b1;
    in_data  = push_bits[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 2) in_data = push_bits[i+1];
      else in_valid = 1'b0;
      check_eq($sformatf("b2b_rails%0d", i), {o_t, o_f}, exp_rails[i]);
      check_eq($sformatf("b2b_prech%0d", i), prech2, exp_prech[i]);
      check_eq($sformatf("b2b_valid%0d", i), o_valid, exp_vld[i]);
    end
    repeat (2) @(negedge clk);
    check_eq("b2b_fault", dr_fault, 1'b0);
    check_eq("b2b_sb_drained", sb_q.size(), 0);

    // EVAL_CYCLES = 3, single 0
    r3_in_valid = 1'b1;
    r3_in_data  = 1'b0;
    @(negedge clk);
    r3_in_valid = 1'b0;
    low_cnt = 0;
    vld_cnt = 0;
    got_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!r3_prech2) low_cnt++;
      if (r3_valid) begin
        vld_cnt++;
        got_data = r3_data;
      end
    end
    check_eq("e3_low_cycles", low_cnt, 3);
    check_eq("e3_valid_count", vld_cnt, 1);
    check_eq("e3_data", got_data, 1'b0);
    check_eq("e3_fault", r3_dr_fault, 1'b0);

    // invalid 11 at the sample point
    sb_q.push_back('{err: 1'b1, data: 1'b0, oe: 1'b1});
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("err_in_eval", prech2, 1'b0);
    force_en = 1'b1;
    force_rails = 2'b11;
    @(negedge clk);
    force_en = 1'b0;
    check_eq("err_fault", dr_fault, 1'b1);
    check_eq("err_cnt", fault_cnt, 8'd1);

    // settle cycle ignored; second PRECH cycle bad rails plus F_ctrl counts once
    sb_q.push_back('{err: 1'b0, data: 1'b0, oe: 1'b1});
    in_valid = 1'b1;
    in_data  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    force_en = 1'b1;
    force_rails = 2'b11;
    @(negedge clk);
    check_eq("settle_ignored_cnt", fault_cnt, 8'd1);
    force_rails = 2'b10;
    f_ctrl = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    f_ctrl = 1'b0;
    check_eq("prech_bad_cnt", fault_cnt, 8'd2);
    @(negedge clk);
    check_eq("prech_bad_hold", {dr_fault, fault_cnt}, {1'b1, 8'd2});

    // clear, then clear colliding with a fault
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("clr", {dr_fault, fault_cnt}, {1'b0, 8'd0});
    fault_clr = 1'b1;
    f_ctrl = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    f_ctrl = 1'b0;
    check_eq("clr_vs_fault", {dr_fault, fault_cnt}, {1'b1, 8'd1});

    // saturation
    f_ctrl = 1'b1;
    repeat (300) @(negedge clk);
    f_ctrl = 1'b0;
    @(negedge clk);
    check_eq("cnt_saturate", fault_cnt, 8'd255);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("clr_after_sat", {dr_fault, fault_cnt}, {1'b0, 8'd0});

    // fill with run low, then drain in order
    run = 1'b0;
    t_top = 1'b1;
    sb_q.push_back('{err: 1'b0, data: 1'b1, oe: 1'b0});
    sb_q.push_back('{err: 1'b0, data: 1'b0, oe: 1'b0});
    in_valid = 1'b1;
    in_data  = 1'b1;
    check_eq("fill_ready0", in_ready, 1'b1);
    @(negedge clk);
    in_data = 1'b0;
    check_eq("fill_ready1", in_ready, 1'b1);
    @(negedge clk);
    in_data = 1'b1;
    check_eq("fill_full", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!prech2) low_cnt++;
    end
    check_eq("fill_no_eval", low_cnt, 0);
    run = 1'b1;
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("drain_done", sb_q.size(), 0);
    t_top = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of EVAL
    run = 1'b0;
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(negedge clk);
    in_data = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    run = 1'b1;
    waited = 0;
    while (prech2 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_eq("mid_eval_reached", prech2, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_prech2", prech2, 1'b1);
    check_eq("mid_rst_rails", {o_t, o_f}, 2'b00);
    check_eq("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!prech2) low_cnt++;
    end
    check_eq("mid_rst_fifo_empty", low_cnt, 0);

    repeat (2) @(negedge clk);
    check_eq("sb_final_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
